apuf_multi_eval_ctrl: RTL and testbench

APUF_MULTI_EVAL_CTRL -- requirements
Module: apuf_multi_eval_ctrl

---
 rtl/apuf_multi_eval_ctrl.sv | 177 +++++++++++++++++
 tb/tb_apuf_multi_eval_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apuf_multi_eval_ctrl.sv
// Multi-evaluation controller for a bank of arbiter PUF channels sharing one challenge.
// Each request is evaluated NREP times; per-channel results are majority voted and flagged stable.

module apuf_chan_vote #(
    parameter int NREP = 7,
    parameter int CW   = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_acc,
    input  logic i_bit,
    output logic o_maj,
    output logic o_stab
);
    localparam logic [CW-1:0] HALF = CW'(NREP / 2);
    localparam logic [CW-1:0] FULL = CW'(NREP);

    logic [CW-1:0] r_ones;
    logic [CW-1:0] w_ones_nxt;

    // Vote is taken on the post-accumulate count so the last sample lands in the result
    assign w_ones_nxt = (i_acc && i_bit && (r_ones != FULL)) ? r_ones + 1'b1 : r_ones;
    assign o_maj      = (w_ones_nxt > HALF);
    assign o_stab     = (w_ones_nxt == '0) || (w_ones_nxt == FULL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_ones <= '0;
        else if (i_clr) r_ones <= '0;
        else            r_ones <= w_ones_nxt;
    end
endmodule

module apuf_multi_eval_ctrl #(
    parameter int NSTAGE = 64,
    parameter int NCHAN  = 4,
    parameter int NREP   = 7,
    parameter int SETTLE = 4,
    parameter int TMO    = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [NSTAGE-1:0] i_chal,
    output logic              o_busy,
    output logic [NSTAGE-1:0] o_cT,
    output logic [NSTAGE-1:0] o_cB,
    output logic              o_tig,
    input  logic [NCHAN-1:0]  i_ch_ready,
    input  logic [NCHAN-1:0]  i_ch_bit,
    output logic              o_resp_valid,
    output logic [NCHAN-1:0]  o_resp,
    output logic [NCHAN-1:0]  o_stable,
    output logic              o_err
);
    localparam int CW = $clog2(NREP + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_ACCUM, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [NSTAGE-1:0] r_chal;
    logic [CW-1:0]     r_rep;
    logic [SW-1:0]     r_set;
    logic [TW-1:0]     r_tmo;
    logic [NCHAN-1:0]  r_resp, r_stable;
    logic              r_err;

    logic              w_all_rdy, w_last, w_tmo_exp;
    logic              w_accept, w_acc, w_timeout;
    logic [NCHAN-1:0]  w_maj, w_stab;

    assign w_all_rdy = &i_ch_ready;
    assign w_last    = (r_rep == CW'(NREP - 1));
    assign w_tmo_exp = (r_tmo == TW'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_acc     = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD:  if (r_set == '0) w_next = S_FIRE;
            S_FIRE:  w_next = S_WAIT;
            S_WAIT: begin
                if (w_all_rdy) begin
                    w_next = S_ACCUM;
                end else if (w_tmo_exp) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_ACCUM: begin
                w_acc  = 1'b1;
                w_next = w_last ? S_DONE : S_LOAD;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chal   <= '0;
            r_rep    <= '0;
            r_set    <= '0;
            r_tmo    <= '0;
            r_resp   <= '0;
            r_stable <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_chal <= i_chal;
                r_rep  <= '0;
            end

            // Settle counter is armed on every LOAD entry, from IDLE or from ACCUM
            if ((w_next == S_LOAD) && (r_state != S_LOAD))
                r_set <= SW'(SETTLE - 1);
            else if ((r_state == S_LOAD) && (r_set != '0))
                r_set <= r_set - 1'b1;

            if (r_state == S_FIRE)
                r_tmo <= TW'(TMO);
            else if ((r_state == S_WAIT) && !w_all_rdy && (r_tmo != '0))
                r_tmo <= r_tmo - 1'b1;

            if (w_acc)
                r_rep <= r_rep + 1'b1;

            if (w_acc && w_last) begin
                r_resp   <= w_maj;
                r_stable <= w_stab;
                r_err    <= 1'b0;
            end else if (w_timeout) begin
                r_resp   <= '0;
                r_stable <= '0;
                r_err    <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        apuf_chan_vote #(.NREP(NREP), .CW(CW)) u_vote (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (w_accept),
            .i_acc   (w_acc),
            .i_bit   (i_ch_bit[g]),
            .o_maj   (w_maj[g]),
            .o_stab  (w_stab[g])
        );
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_tig        = (r_state == S_FIRE);
    assign o_resp_valid = (r_state == S_DONE);
    assign o_cT         = r_chal;
    assign o_cB         = r_chal;
    assign o_resp       = r_resp;
    assign o_stable     = r_stable;
    assign o_err        = r_err;
endmodule

// File: tb/tb_apuf_multi_eval_ctrl.sv
// Bench for apuf_multi_eval_ctrl: table vectors, random patterns against a counting model,
// plus timeout, mid-evaluation reset and held-start sequences.

module tb_apuf_multi_eval_ctrl;
    localparam int NSTAGE = 64;
    localparam int NCHAN  = 4;
    localparam int NREP   = 7;
    localparam int SETTLE = 4;
    localparam int TMO    = 255;

    typedef logic [NREP-1:0][NCHAN-1:0] pat_t;
    typedef struct {
        logic [NSTAGE-1:0] chal;
        pat_t              pat;
        logic [NCHAN-1:0]  resp;
        logic [NCHAN-1:0]  stab;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start;
    logic [NSTAGE-1:0] i_chal;
    logic              o_busy, o_tig, o_resp_valid, o_err;
    logic [NSTAGE-1:0] o_cT, o_cB;
    logic [NCHAN-1:0]  i_ch_ready, i_ch_bit, o_resp, o_stable;

    apuf_multi_eval_ctrl #(
        .NSTAGE(NSTAGE), .NCHAN(NCHAN), .NREP(NREP), .SETTLE(SETTLE), .TMO(TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_chal       (i_chal),
        .o_busy       (o_busy),
        .o_cT         (o_cT),
        .o_cB         (o_cB),
        .o_tig        (o_tig),
        .i_ch_ready   (i_ch_ready),
        .i_ch_bit     (i_ch_bit),
        .o_resp_valid (o_resp_valid),
        .o_resp       (o_resp),
        .o_stable     (o_stable),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Counting model: a channel's vote is the majority of its NREP bits.
    function automatic void ref_eval(input pat_t p, output logic [NCHAN-1:0] r,
                                     output logic [NCHAN-1:0] s);
        for (int c = 0; c < NCHAN; c++) begin
            int n = 0;
            for (int k = 0; k < NREP; k++) n += int'(p[k][c]);
            r[c] = (2 * n > NREP);
            s[c] = (n == 0) || (n == NREP);
        end
    endfunction

    // Channel model and protocol monitor
    pat_t              cur_pat;
    int                dly = 2;
    logic [NCHAN-1:0]  rmask = '1;
    int                tig_cnt = 0, rv_cnt = 0, wcnt = 0, idx = 0, sc = 0;
    logic              prev_tig = 1'b0;
    logic [NSTAGE-1:0] last_ct = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            wcnt = 0;
        end else if (o_tig) begin
            wcnt       = dly;
            i_ch_ready = '0;
            i_ch_bit   = NCHAN'($urandom);
            idx        = tig_cnt % NREP;
            tig_cnt++;
        end else if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) begin
                i_ch_ready = rmask;
                i_ch_bit   = cur_pat[idx];
            end
        end
        if (o_resp_valid) rv_cnt++;
        if (o_tig) begin
            chk("tig_width", 64'(prev_tig), 64'(0));
            chk("settle_before_tig", 64'(sc >= SETTLE), 64'(1));
            sc = 0;
        end else if (!o_busy) sc = 0;
        else if (o_cT != last_ct) sc = 1;
        else sc++;
        prev_tig = o_tig;
        last_ct  = o_cT;
    end

    task automatic run_eval(input logic [NSTAGE-1:0] ch, input pat_t p, input int d,
                            input logic [NCHAN-1:0] m, output int lat);
        @(negedge clk);
        cur_pat = p; dly = d; rmask = m; tig_cnt = 0; rv_cnt = 0;
        i_chal  = ch;
        i_start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            i_start = 1'b0;
            lat++;
        end while (!o_resp_valid && lat < 2000);
        chk("resp_valid_seen", 64'(o_resp_valid), 64'(1));
    endtask

    task automatic finish_eval(input int exp_tigs);
        repeat (2) @(negedge clk);
        chk("resp_valid_once", 64'(rv_cnt), 64'(1));
        chk("tig_count", 64'(tig_cnt), 64'(exp_tigs));
        chk("idle_after_done", 64'(o_busy), 64'(0));
    endtask

    vec_t              tbl[4];
    int                lat, n, k, seen, after, tl;
    logic [NCHAN-1:0]  er, es;
    logic [NSTAGE-1:0] ch;
    pat_t              p;
    int                d;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].chal = 64'hDEAD_BEEF_0123_4567;
        tbl[0].pat  = {7{4'b1010}};
        tbl[0].resp = 4'b1010; tbl[0].stab = 4'b1111;
        tbl[1].chal = 64'h0F0F_F0F0_AAAA_5555;
        tbl[1].pat  = {4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
        tbl[1].resp = 4'b0001; tbl[1].stab = 4'b1110;
        tbl[2].chal = 64'hFFFF_FFFF_FFFF_FFFF;
        tbl[2].pat  = {4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF};
        tbl[2].resp = 4'b1111; tbl[2].stab = 4'b0000;
        tbl[3].chal = 64'h1;
        tbl[3].pat  = {4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b1110, 4'b1110, 4'b1110};
        tbl[3].resp = 4'b1100; tbl[3].stab = 4'b1001;

        rst_n = 1'b0; i_start = 1'b0; i_chal = '0; i_ch_ready = '0; i_ch_bit = '0;
        #23;
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_tig", 64'(o_tig), 64'(0));
        chk("rst_rv", 64'(o_resp_valid), 64'(0));
        chk("rst_outs", 64'({o_resp, o_stable, o_err}), 64'(0));
        chk("rst_cT", o_cT, 64'(0));
        chk("rst_cB", o_cB, 64'(0));
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_eval(tbl[i].chal, tbl[i].pat, 2, '1, lat);
            chk($sformatf("tbl%0d_resp", i), 64'(o_resp), 64'(tbl[i].resp));
            chk($sformatf("tbl%0d_stable", i), 64'(o_stable), 64'(tbl[i].stab));
            chk($sformatf("tbl%0d_err", i), 64'(o_err), 64'(0));
            chk($sformatf("tbl%0d_cT", i), o_cT, tbl[i].chal);
            chk($sformatf("tbl%0d_cB", i), o_cB, tbl[i].chal);
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(NREP * (SETTLE + 3) + 1 + NREP));
            finish_eval(NREP);
        end

        for (int i = 0; i < 6; i++) begin
            ch = {$urandom, $urandom};
            p  = pat_t'($urandom);
            d  = $urandom_range(1, 4);
            ref_eval(p, er, es);
            run_eval(ch, p, d, '1, lat);
            chk($sformatf("rnd%0d_resp", i), 64'(o_resp), 64'(er));
            chk($sformatf("rnd%0d_stable", i), 64'(o_stable), 64'(es));
            chk($sformatf("rnd%0d_err", i), 64'(o_err), 64'(0));
            chk($sformatf("rnd%0d_cT", i), o_cT, ch);
            chk($sformatf("rnd%0d_latency", i), 64'(lat),
                64'(NREP * (SETTLE + 3) + 1 + NREP * (d - 1)));
            finish_eval(NREP);
        end

        // Channel 2 never reports: WAIT must give up after TMO cycles
        run_eval(64'h5A5A, {7{4'b1111}}, 2, 4'b1011, lat);
        chk("tmo_err", 64'(o_err), 64'(1));
        chk("tmo_resp", 64'(o_resp), 64'(0));
        chk("tmo_stable", 64'(o_stable), 64'(0));
        chk("tmo_latency", 64'(lat), 64'(1 + SETTLE + 1 + TMO));
        finish_eval(1);

        // Reset during the third WAIT, then a fresh evaluation
        @(negedge clk);
        cur_pat = {7{4'b1111}}; dly = 2; rmask = '1; tig_cnt = 0;
        i_chal = 64'hCAFE; i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        k = 0; n = 0;
        while (k < 3 && n < 500) begin
            @(negedge clk); n++;
            if (o_tig) k++;
        end
        chk("third_tig_seen", 64'(k), 64'(3));
        @(negedge clk);
        chk("busy_in_wait", 64'(o_busy), 64'(1));
        #2 rst_n = 1'b0;
        wcnt = 0; i_ch_ready = '0;
        #1;
        chk("midrst_busy_tig_rv", 64'({o_busy, o_tig, o_resp_valid}), 64'(0));
        chk("midrst_outs", 64'({o_resp, o_stable, o_err}), 64'(0));
        chk("midrst_cT", o_cT, 64'(0));
        chk("midrst_cB", o_cB, 64'(0));
        @(negedge clk); rst_n = 1'b1;
        p = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
        ref_eval(p, er, es);
        run_eval(64'hBEEF, p, 2, '1, lat);
        chk("fresh_resp", 64'(o_resp), 64'(er));
        chk("fresh_resp_const", 64'(o_resp), 64'(4'b0000));
        chk("fresh_stable", 64'(o_stable), 64'(4'b1110));
        chk("fresh_err", 64'(o_err), 64'(0));
        chk("fresh_latency", 64'(lat), 64'(NREP * (SETTLE + 3) + 1 + NREP));
        finish_eval(NREP);

        // start held high across two evaluations
        @(negedge clk);
        cur_pat = {7{4'b1010}}; dly = 2; rmask = '1; tig_cnt = 0; rv_cnt = 0;
        i_chal = 64'h7777; i_start = 1'b1;
        seen = 0; after = 0; tl = 0; n = 0;
        while (seen < 2 && n < 1000) begin
            @(negedge clk); n++;
            if (o_tig) tl++;
            if (o_resp_valid) seen++;
            else if (seen == 1) begin
                after++;
                if (after == 1) chk("held_idle_after_done", 64'(o_busy), 64'(0));
                if (after == 2) chk("held_restart", 64'(o_busy), 64'(1));
            end
        end
        i_start = 1'b0;
        chk("held_evals", 64'(seen), 64'(2));
        chk("held_tigs", 64'(tl), 64'(2 * NREP));
        chk("held_resp", 64'(o_resp), 64'(4'b1010));
        chk("held_stable", 64'(o_stable), 64'(4'b1111));
        repeat (3) @(negedge clk);
        chk("held_rv_total", 64'(rv_cnt), 64'(2));
        chk("held_final_idle", 64'(o_busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
